pipeline_sink: RTL and testbench

- Receiving end of the en/valid delay-line interface used across the FFT datapath.
- Sits at the output of an enable-stalled pipeline and captures each word the pipeline presents.
- Buffers those words in a small first-word-fall-through FIFO and hands them to a downstream ready/valid consumer.
- Drives the upstream pipeline's enable so that backpressure stalls the whole delay line and no sample is ever lost.

---
 rtl/pipeline_sink_pkg.sv | 15 +
 rtl/sink_fifo_mem.sv | 27 ++
 rtl/pipeline_sink.sv | 101 ++++++++++
 tb/tb_pipeline_sink.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/pipeline_sink_pkg.sv
// Shared types and sizing helpers for the pipeline_sink FIFO slice.
package pipeline_sink_pkg;

    localparam int unsigned SAMPLE_W   = 16;
    localparam int unsigned FIFO_DEPTH = 4;

    // Pointer width for a power-of-two depth; never narrower than one bit.
    function automatic int unsigned ptr_w(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic [ptr_w(FIFO_DEPTH):0] count_t;

endpackage

// File: rtl/sink_fifo_mem.sv
// Sample storage for pipeline_sink: synchronous write, asynchronous (FWFT) read.
module sink_fifo_mem
    import pipeline_sink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SAMPLE_W,
    parameter int unsigned DEPTH      = FIFO_DEPTH,
    parameter int unsigned PTR_W      = ptr_w(DEPTH)
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [PTR_W-1:0]             waddr,
    input  logic signed [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]             raddr,
    output logic signed [DATA_WIDTH-1:0] rdata
);

    logic signed [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pipeline_sink.sv
// Receiving end of the en/valid delay line: FWFT buffer with registered upstream enable.
// Define PIPE_SINK_LEVEL_EN to add the level_out / hwm_out occupancy ports.
module pipeline_sink
    import pipeline_sink_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SAMPLE_W,
    parameter int unsigned DEPTH      = FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] src_data_in,
    input  logic                         src_valid_in,
    output logic                         en_out,
    output logic signed [DATA_WIDTH-1:0] dst_data_out,
    output logic                         dst_valid_out,
`ifdef PIPE_SINK_LEVEL_EN
    output logic [ptr_w(DEPTH):0]        level_out,
    output logic [ptr_w(DEPTH):0]        hwm_out,
`endif
    input  logic                         dst_ready_in
);

    localparam int unsigned PTR_W = ptr_w(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             en_q, en_d;
    logic             wr, rd;

    // The upstream shifts on the same edge we capture, so each word lands exactly once.
    assign wr = en_q & src_valid_in;
    assign rd = dst_valid_out & dst_ready_in;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        case ({wr, rd})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (wr) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (rd) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        // Registered enable keeps dst_ready_in off any combinational path to en_out.
        en_d = (count_d < DEPTH_C);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            en_q     <= 1'b1;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            en_q     <= en_d;
        end
    end

    sink_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .PTR_W      (PTR_W)
    ) u_mem (
        .clk   (clk),
        .we    (wr),
        .waddr (wr_ptr_q),
        .wdata (src_data_in),
        .raddr (rd_ptr_q),
        .rdata (dst_data_out)
    );

    assign en_out        = en_q;
    assign dst_valid_out = (count_q != '0);

`ifdef PIPE_SINK_LEVEL_EN
    logic [CNT_W-1:0] hwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            hwm_q <= '0;
        end else if (count_d > hwm_q) begin
            hwm_q <= count_d;
        end
    end

    assign level_out = count_q;
    assign hwm_out   = hwm_q;
`endif

endmodule

// File: tb/tb_pipeline_sink.sv
// Self-checking bench for pipeline_sink: directed plan steps then randomized traffic vs a queue model.
module tb_pipeline_sink;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic                 clk;
    logic                 rst;
    logic signed [DW-1:0] src_data_in;
    logic                 src_valid_in;
    logic                 en_out;
    logic signed [DW-1:0] dst_data_out;
    logic                 dst_valid_out;
    logic                 dst_ready_in;
`ifdef PIPE_SINK_LEVEL_EN
    logic [CW-1:0]        level_out;
    logic [CW-1:0]        hwm_out;
    int                   model_hwm;
`endif

    pipeline_sink #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .src_data_in   (src_data_in),
        .src_valid_in  (src_valid_in),
        .en_out        (en_out),
        .dst_data_out  (dst_data_out),
        .dst_valid_out (dst_valid_out),
`ifdef PIPE_SINK_LEVEL_EN
        .level_out     (level_out),
        .hwm_out       (hwm_out),
`endif
        .dst_ready_in  (dst_ready_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference: FIFO contents, upstream words still to deliver, and expected enable.
    logic signed [DW-1:0] model_q[$];
    logic signed [DW-1:0] src_q[$];
    logic                 model_en;

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_state();
        check("en_out", 32'(en_out), 32'(model_en));
        check("dst_valid", 32'(dst_valid_out), 32'(model_q.size() != 0));
        if (model_q.size() != 0) begin
            check("dst_data", 32'(dst_data_out), 32'(model_q[0]));
        end
`ifdef PIPE_SINK_LEVEL_EN
        check("level", 32'(level_out), model_q.size());
        check("hwm", 32'(hwm_out), model_hwm);
`endif
    endtask

    // One clock: drive at negedge, update model at posedge, check 1 time unit later.
    task automatic cycle(input logic do_rst, input logic want_valid, input logic ready);
        logic wr, rd;
        rst          = do_rst;
        dst_ready_in = ready;
        if (src_q.size() > 0) begin
            src_valid_in = want_valid;
            src_data_in  = src_q[0];
        end else begin
            src_valid_in = 1'b0;
            src_data_in  = DW'($urandom);
        end
        wr = !do_rst && model_en && src_valid_in;
        rd = !do_rst && (model_q.size() != 0) && ready;
        @(posedge clk);
        if (do_rst) begin
            model_q.delete();
            src_q.delete();
            model_en = 1'b1;
`ifdef PIPE_SINK_LEVEL_EN
            model_hwm = 0;
`endif
        end else begin
            if (rd) void'(model_q.pop_front());
            if (wr) model_q.push_back(src_q.pop_front());
            model_en = (model_q.size() < DEPTH);
`ifdef PIPE_SINK_LEVEL_EN
            if (model_q.size() > model_hwm) model_hwm = model_q.size();
`endif
        end
        #1;
        check_state();
        @(negedge clk);
    endtask

    initial begin
        rst          = 1'b1;
        src_valid_in = 1'b0;
        src_data_in  = '0;
        dst_ready_in = 1'b0;
        model_en     = 1'b1;
`ifdef PIPE_SINK_LEVEL_EN
        model_hwm    = 0;
`endif

        // Reset then idle
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("reset_en", 32'(en_out), 32'd1);
        check("reset_valid", 32'(dst_valid_out), 32'd0);
        cycle(1'b0, 1'b0, 1'b1);

        // Streaming with ready held high, including a negative sample
        src_q.push_back(16'sd1);
        src_q.push_back(16'sd2);
        src_q.push_back(16'sd3);
        src_q.push_back(-16'sd4);
        cycle(1'b0, 1'b1, 1'b1);
        check("stream_first", 32'(dst_data_out), 32'sd1);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 1'b1);

        // Backpressure: six words, only four fit, upstream holds 14
        for (int i = 10; i <= 15; i++) src_q.push_back(DW'(i));
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b0);
        check("bp_en_low", 32'(en_out), 32'd0);
        check("bp_head", 32'(dst_data_out), 32'sd10);
        for (int i = 0; i < 9; i++) cycle(1'b0, 1'b1, 1'b1);
        check("bp_drained", 32'(dst_valid_out), 32'd0);

        // Simultaneous read/write at DEPTH-1
        for (int i = 20; i <= 23; i++) src_q.push_back(DW'(i));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1);
        check("rw_en", 32'(en_out), 32'd1);
        check("rw_head", 32'(dst_data_out), 32'sd21);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1);

        // Gaps in valid
        src_q.push_back(16'sd40);
        src_q.push_back(16'sd41);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        check("gap_empty", 32'(dst_valid_out), 32'd0);

        // Reset mid-burst with three words buffered
        for (int i = 30; i <= 33; i++) src_q.push_back(DW'(i));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        check("mid_rst_valid", 32'(dst_valid_out), 32'd0);
        check("mid_rst_en", 32'(en_out), 32'd1);
        cycle(1'b0, 1'b0, 1'b1);

        // Randomized traffic: two readiness biases, rare resets
        for (int i = 0; i < 600; i++) begin
            logic rdy;
            if (src_q.size() < 2) src_q.push_back(DW'($urandom));
            rdy = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, rdy);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
